// File: rtl/cache_mux_arbiter_if.sv
// rtl/cache_mux_arbiter_if.sv - requester/cache handshake bundle for cache_mux_arbiter (lock signal with MUX_ARB_LOCK_EN)
interface cache_mux_arbiter_if #(
    parameter int WIDTH = 3
);
    logic             req_0;
    logic [WIDTH-1:0] din_0;
    logic             ack_0;
    logic             req_1;
    logic [WIDTH-1:0] din_1;
    logic             ack_1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;

    modport master (
        output req_0, din_0, req_1, din_1, out_ready, lock,
        input  ack_0, ack_1, sel, out_valid, out_data
    );
    modport slave (
        input  req_0, din_0, req_1, din_1, out_ready, lock,
        output ack_0, ack_1, sel, out_valid, out_data
    );
`else
    modport master (
        output req_0, din_0, req_1, din_1, out_ready,
        input  ack_0, ack_1, sel, out_valid, out_data
    );
    modport slave (
        input  req_0, din_0, req_1, din_1, out_ready,
        output ack_0, ack_1, sel, out_valid, out_data
    );
`endif
endinterface

// File: rtl/cache_mux_arbiter.sv
// rtl/cache_mux_arbiter.sv - two-requester round-robin burst arbiter with registered output stage (optional MUX_ARB_LOCK_EN)
module cache_mux_arbiter #(
    parameter int WIDTH     = 3,
    parameter int MAX_BURST = 4
) (
    input logic                clk,
    input logic                rst_n,
    cache_mux_arbiter_if.slave bus
);
    localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state;
    logic             sel_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [3:0]       burst_cnt;
    logic             last_served;

    logic space, ack_0, ack_1, beat;
    logic owner_id, owner_req, other_req, lock_hold, release_now;

    always_comb begin
        space       = ~out_valid_q | bus.out_ready;
        ack_0       = rst_n & (state == OWN0) & bus.req_0 & space;
        ack_1       = rst_n & (state == OWN1) & bus.req_1 & space;
        beat        = ack_0 | ack_1;
        owner_id    = (state == OWN1);
        owner_req   = owner_id ? bus.req_1 : bus.req_0;
        other_req   = owner_id ? bus.req_0 : bus.req_1;
`ifdef MUX_ARB_LOCK_EN
        lock_hold   = bus.lock;
`else
        lock_hold   = 1'b0;
`endif
        // The beat that completes the burst ends ownership at the same edge.
        release_now = ~owner_req | (beat & (burst_cnt >= BURST_LAST) & ~lock_hold);
    end

    assign bus.ack_0     = ack_0;
    assign bus.ack_1     = ack_1;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            burst_cnt   <= 4'd0;
            last_served <= 1'b1;
        end else begin
            if (beat) begin
                out_data_q  <= sel_q ? bus.din_1 : bus.din_0;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.req_0 & (~bus.req_1 | last_served)) begin
                        state <= OWN0;
                        sel_q <= 1'b0;
                    end else if (bus.req_1) begin
                        state <= OWN1;
                        sel_q <= 1'b1;
                    end
                end
                default: begin
                    if (release_now) begin
                        last_served <= owner_id;
                        burst_cnt   <= 4'd0;
                        if (other_req) begin
                            state <= owner_id ? OWN0 : OWN1;
                            sel_q <= ~owner_id;
                        end else if (!owner_req) begin
                            state <= IDLE;
                        end
                    end else if (beat && burst_cnt != BURST_MAX) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/cache_mux_arbiter.md
Name: cache_mux_arbiter

Overview:
- Two-requester round-robin arbiter that shares one WIDTH-bit 2:1 select path between requester 0 and requester 1.
- Decides ownership, drives the select line, and registers the selected data into a single-entry output stage with a valid/ready handshake toward the cache side.
- Bounds each ownership burst so neither requester can starve the other.

Parameters:
- WIDTH, 3, data width of each requester input and of out_data.
- MAX_BURST, 4, maximum beats per grant before ownership is forcibly re-arbitrated; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_0  input  1  requester 0 has a beat on din_0.
- din_0  input  WIDTH  requester 0 data.
- ack_0  output  1  beat from requester 0 accepted this cycle.
- req_1  input  1  requester 1 has a beat on din_1.
- din_1  input  WIDTH  requester 1 data.
- ack_1  output  1  beat from requester 1 accepted this cycle.
- sel  output  1  current owner (0 = din_0, 1 = din_1).
- out_valid  output  1  out_data holds a beat.
- out_data  output  WIDTH  registered selected data.
- out_ready  input  1  downstream consumes out_data when out_valid is high.
- lock  input  1  present only with MUX_ARB_LOCK_EN.

Behaviour:
- Reset (rst_n low at a clock edge) values: state=IDLE, sel=0, out_valid=0, out_data=0, burst count=0, last_served=1 (requester 0 wins first contention). Reset mid-burst discards the buffered beat. ack_0 and ack_1 are 0 whenever rst_n is low.
- States:
  - IDLE: no owner.
  - OWN0: requester 0 owns the path.
  - OWN1: requester 1 owns the path.
- Stage free: space = ~out_valid | out_ready.
- Acks are combinational: ack_i = (state == OWN_i) & req_i & space. Ack is never asserted in IDLE.
- A beat transfers on an edge where ack_i=1:
  - out_data <= din_i, out_valid <= 1, burst count increments.
- out_valid clears when out_ready=1 and no new beat loads in the same cycle. A simultaneous drain and load keeps out_valid=1 with the new data, so full throughput is one beat per cycle.
- IDLE transitions:
  - only req_0 set -> OWN0.
  - only req_1 set -> OWN1.
  - both set -> owner is ~last_served.
  - none set -> stay in IDLE.
  - The arbitration cycle itself has no ack, so the first beat is accepted 1 cycle after the request is seen.
- OWN_i release: ownership ends at the edge where the owner's req_i=0, or where the beat accepted brings the burst count to MAX_BURST. At release:
  - last_served <= i, burst count <= 0.
  - Next state is OWN_other if req_other=1, else OWN_i if req_i=1 (re-grant, new burst), else IDLE.
  - There is no bubble when handing directly to the other requester.
- sel is registered: it equals the owner in OWN states and holds the last owner in IDLE.
- Backpressure (out_ready=0 with the stage full) stalls acks and does not advance the burst count. The owner keeps the grant indefinitely while req stays high.
- Data width: out_data is exactly WIDTH bits, no extension. The burst counter is 4 bits.

Optional Feature:
- Macro MUX_ARB_LOCK_EN.
- Defined: adds the lock port. While the owner holds lock=1, the MAX_BURST release is suppressed and the count saturates at MAX_BURST. Release then occurs only on req drop or on the first accepted beat with lock=0. lock is ignored in IDLE.
- Undefined: no lock port; the burst limit is always enforced.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_0=1 -> ack_0=0, out_valid=0, sel=0, out_data=0. Release rst_n -> OWN0 next cycle, first ack_0 one cycle later.
- Contention, MAX_BURST=4, out_ready=1, both requests high, din_0=3'h5, din_1=3'h2 -> out_data sequence 5,5,5,5,2,2,2,2,5..., sel toggles every 4 beats, no idle cycle at handover.
- Single requester: req_1 only for 10 beats -> 10 consecutive beats of din_1; re-grant after the 4th beat has no gap; ack_0 never asserted.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_valid=1, out_data frozen, acks 0, burst count unchanged; resumes with out_ready=1.
- Early release: req_0 drops after 2 beats while req_1=1 -> OWN1 next edge, last_served=0.
- Lock (with MUX_ARB_LOCK_EN): lock=1 on owner 0 with both requests high for 8 beats -> 8 consecutive din_0 beats; lock=0 -> grant moves to requester 1 after the next beat.
